// File: rtl/match_sequencer_if.sv
// Bundle of the match sequencer's pulse/level inputs and its status outputs.
// Ports: tick_1hz/start/miss1/miss2 in; state/stop/ball_reset/serve_dir/scores/time/winner out.
// master = stimulus side, slave = sequencer side.
interface match_sequencer_if;
  logic       tick_1hz;
  logic       start;
  logic       miss1;
  logic       miss2;
  logic [1:0] state;
  logic       stop;
  logic       ball_reset;
  logic       serve_dir;
  logic [2:0] score1;
  logic [2:0] score2;
  logic [3:0] min;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [1:0] winner;

  modport master (
    output tick_1hz, start, miss1, miss2,
    input  state, stop, ball_reset, serve_dir, score1, score2,
           min, sec_tens, sec_ones, winner
  );

  modport slave (
    input  tick_1hz, start, miss1, miss2,
    output state, stop, ball_reset, serve_dir, score1, score2,
           min, sec_tens, sec_ones, winner
  );
endinterface

// File: rtl/match_sequencer.sv
// Match control for a two-player ball game: IDLE -> SERVE -> PLAY -> OVER, scores and BCD clock.
// Ports: clk, rst (async, active-high), bus (slave modport of match_sequencer_if).
// Outputs update one clk after the causing input; stop is decoded from the state register.
module match_sequencer #(
  parameter int MATCH_MIN   = 3,
  parameter int SERVE_TICKS = 2,
  parameter int WIN_SCORE   = 7
) (
  input  logic              clk,
  input  logic              rst,
  match_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    SERVE = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [3:0] MIN_INIT   = 4'(MATCH_MIN);
  localparam logic [3:0] SERVE_INIT = 4'(SERVE_TICKS);
  localparam logic [2:0] WIN        = 3'(WIN_SCORE);

  state_t     state_q, state_n;
  logic       start_q, start_arm_q;
  logic [2:0] s1_q, s1_n, s2_q, s2_n;
  logic [3:0] min_q, min_n, tens_q, tens_n, ones_q, ones_n;
  logic [3:0] cnt_q, cnt_n;
  logic       sd_q, sd_n;
  logic       br_q, br_n;
  logic [1:0] win_q, win_n;
  logic [3:0] dec_min, dec_tens, dec_ones;
  logic       scored;
  logic       start_edge;

  // start_arm_q stays low after reset until start is seen low, so a button
  // held through reset release cannot masquerade as a fresh press.
  assign start_edge = bus.start & ~start_q & start_arm_q;

  // One-second BCD decrement of the match clock, floored at 0:00.
  always_comb begin
    dec_min  = min_q;
    dec_tens = tens_q;
    dec_ones = ones_q;
    if (ones_q != 4'd0) begin
      dec_ones = ones_q - 4'd1;
    end else if (tens_q != 4'd0) begin
      dec_ones = 4'd9;
      dec_tens = tens_q - 4'd1;
    end else if (min_q != 4'd0) begin
      dec_ones = 4'd9;
      dec_tens = 4'd5;
      dec_min  = min_q - 4'd1;
    end
  end

  always_comb begin
    state_n = state_q;
    s1_n    = s1_q;
    s2_n    = s2_q;
    min_n   = min_q;
    tens_n  = tens_q;
    ones_n  = ones_q;
    cnt_n   = cnt_q;
    sd_n    = sd_q;
    br_n    = 1'b0;
    win_n   = 2'd0;
    scored  = 1'b0;
    case (state_q)
      IDLE: begin
        s1_n   = 3'd0;
        s2_n   = 3'd0;
        min_n  = MIN_INIT;
        tens_n = 4'd0;
        ones_n = 4'd0;
        if (start_edge) begin
          state_n = SERVE;
          br_n    = 1'b1;
          cnt_n   = SERVE_INIT;
        end
      end
      SERVE: begin
        if (bus.tick_1hz && cnt_q != 4'd0) cnt_n = cnt_q - 4'd1;
        if (start_edge && cnt_q == 4'd0) state_n = PLAY;
      end
      PLAY: begin
        if (bus.tick_1hz) begin
          min_n  = dec_min;
          tens_n = dec_tens;
          ones_n = dec_ones;
        end
        // miss1 has priority; a simultaneous miss2 is dropped.
        if (bus.miss1) begin
          s2_n   = (s2_q == 3'd7) ? 3'd7 : s2_q + 3'd1;
          sd_n   = 1'b0;
          scored = 1'b1;
        end else if (bus.miss2) begin
          s1_n   = (s1_q == 3'd7) ? 3'd7 : s1_q + 3'd1;
          sd_n   = 1'b1;
          scored = 1'b1;
        end
        // Match end beats the re-serve; the final point is already counted.
        if (s1_n == WIN || s2_n == WIN ||
            (min_n == 4'd0 && tens_n == 4'd0 && ones_n == 4'd0)) begin
          state_n = OVER;
        end else if (scored) begin
          state_n = SERVE;
          br_n    = 1'b1;
          cnt_n   = SERVE_INIT;
        end
      end
      OVER: begin
        if (start_edge) begin
          state_n = IDLE;
          s1_n    = 3'd0;
          s2_n    = 3'd0;
          min_n   = MIN_INIT;
          tens_n  = 4'd0;
          ones_n  = 4'd0;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n == OVER) begin
      if (s1_n > s2_n)      win_n = 2'd1;
      else if (s2_n > s1_n) win_n = 2'd2;
      else                  win_n = 2'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      start_arm_q <= 1'b0;
      s1_q        <= 3'd0;
      s2_q        <= 3'd0;
      min_q       <= MIN_INIT;
      tens_q      <= 4'd0;
      ones_q      <= 4'd0;
      cnt_q       <= 4'd0;
      sd_q        <= 1'b0;
      br_q        <= 1'b0;
      win_q       <= 2'd0;
    end else begin
      state_q     <= state_n;
      start_q     <= bus.start;
      start_arm_q <= start_arm_q | ~bus.start;
      s1_q        <= s1_n;
      s2_q        <= s2_n;
      min_q       <= min_n;
      tens_q      <= tens_n;
      ones_q      <= ones_n;
      cnt_q       <= cnt_n;
      sd_q        <= sd_n;
      br_q        <= br_n;
      win_q       <= win_n;
    end
  end

  assign bus.state      = state_q;
  assign bus.stop       = (state_q != PLAY);
  assign bus.ball_reset = br_q;
  assign bus.serve_dir  = sd_q;
  assign bus.score1     = s1_q;
  assign bus.score2     = s2_q;
  assign bus.min        = min_q;
  assign bus.sec_tens   = tens_q;
  assign bus.sec_ones   = ones_q;
  assign bus.winner     = win_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Self-checking bench for match_sequencer: directed scenarios plus randomized
// stimulus compared every cycle against a seconds-and-scores reference model.
module tb_match_sequencer;
  localparam int P_MIN   = 3;
  localparam int P_SERVE = 2;
  localparam int P_WIN   = 7;
  localparam int FULL_SECS = P_MIN * 60;

  logic clk = 1'b0;
  logic rst = 1'b0;
  match_sequencer_if bus();

  match_sequencer #(.MATCH_MIN(P_MIN), .SERVE_TICKS(P_SERVE), .WIN_SCORE(P_WIN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: state as 0..3, remaining time as plain seconds.
  int m_st, m_s1, m_s2, m_secs, m_sc, m_sd, m_br, m_win, m_ps, m_arm;

  task automatic model_reset();
    m_st = 0; m_s1 = 0; m_s2 = 0; m_secs = FULL_SECS; m_sc = 0;
    m_sd = 0; m_br = 0; m_win = 0; m_ps = 0; m_arm = 0;
  endtask

  task automatic model_step(input bit t, input bit s, input bit a, input bit b);
    bit e;
    bit scored;
    e = s && !m_ps && (m_arm != 0);
    m_arm = (m_arm != 0 || !s) ? 1 : 0;
    m_ps = s;
    m_br = 0;
    scored = 0;
    case (m_st)
      0: begin
        m_s1 = 0; m_s2 = 0; m_secs = FULL_SECS;
        if (e) begin m_st = 2; m_br = 1; m_sc = P_SERVE; end
      end
      2: begin
        if (e && m_sc == 0) m_st = 1;
        else if (t && m_sc > 0) m_sc--;
      end
      1: begin
        if (t && m_secs > 0) m_secs--;
        if (a) begin m_s2 = (m_s2 < 7) ? m_s2 + 1 : 7; m_sd = 0; scored = 1; end
        else if (b) begin m_s1 = (m_s1 < 7) ? m_s1 + 1 : 7; m_sd = 1; scored = 1; end
        if (m_s1 == P_WIN || m_s2 == P_WIN || m_secs == 0) m_st = 3;
        else if (scored) begin m_st = 2; m_br = 1; m_sc = P_SERVE; end
      end
      default: begin
        if (e) begin m_st = 0; m_s1 = 0; m_s2 = 0; m_secs = FULL_SECS; end
      end
    endcase
    m_win = (m_st != 3) ? 0 : (m_s1 > m_s2) ? 1 : (m_s2 > m_s1) ? 2 : 3;
  endtask

  function automatic logic [24:0] exp_vec();
    return {2'(m_st), 1'(m_st != 1), 1'(m_br), 1'(m_sd), 3'(m_s1), 3'(m_s2),
            4'(m_secs / 60), 4'((m_secs % 60) / 10), 4'(m_secs % 10), 2'(m_win)};
  endfunction

  function automatic logic [24:0] dut_vec();
    return {bus.state, bus.stop, bus.ball_reset, bus.serve_dir, bus.score1, bus.score2,
            bus.min, bus.sec_tens, bus.sec_ones, bus.winner};
  endfunction

  // One clock: drive inputs, advance model at the edge, settle 1 time unit.
  task automatic cyc(input bit t, input bit s, input bit a, input bit b);
    bus.tick_1hz = t; bus.start = s; bus.miss1 = a; bus.miss2 = b;
    @(posedge clk);
    model_step(t, s, a, b);
    #1;
    bus.tick_1hz = 1'b0; bus.miss1 = 1'b0; bus.miss2 = 1'b0;
  endtask

  task automatic do_reset();
    bus.tick_1hz = 1'b0; bus.start = 1'b0; bus.miss1 = 1'b0; bus.miss2 = 1'b0;
    rst = 1'b1;
    model_reset();
    #3;
    rst = 1'b0;
    cyc(0, 0, 0, 0);
  endtask

  task automatic serve_to_play();
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic go_play();
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    serve_to_play();
  endtask

  task automatic test_reset();
    bus.tick_1hz = 1'b0; bus.start = 1'b0; bus.miss1 = 1'b0; bus.miss2 = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== {2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 4'd3, 4'd0, 4'd0, 2'd0}) begin
      errors++; $display("FAIL reset_state got %h want %h", dut_vec(), exp_vec());
    end
    #2 rst = 1'b0;
    cyc(0, 0, 0, 0);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_idle got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_start_serve_play();
    do_reset();
    cyc(0, 1, 0, 0);
    checks++;
    if (bus.state !== 2'd2 || bus.ball_reset !== 1'b1 || bus.stop !== 1'b1) begin
      errors++; $display("FAIL enter_serve got st=%0d br=%0d want st=2 br=1", bus.state, bus.ball_reset);
    end
    cyc(0, 0, 0, 0);
    checks++;
    if (bus.ball_reset !== 1'b0) begin
      errors++; $display("FAIL serve_br_pulse got %0d want 0", bus.ball_reset);
    end
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
    checks++;
    if (bus.state !== 2'd2) begin
      errors++; $display("FAIL serve_early_start got %0d want 2", bus.state);
    end
    cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
    checks++;
    if (bus.state !== 2'd2) begin
      errors++; $display("FAIL serve_one_tick got %0d want 2", bus.state);
    end
    cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
    checks++;
    if (bus.state !== 2'd1 || bus.stop !== 1'b0 || bus.ball_reset !== 1'b0 ||
        {bus.min, bus.sec_tens, bus.sec_ones} !== 12'h300) begin
      errors++; $display("FAIL serve_to_play got st=%0d stop=%0d br=%0d want st=1 stop=0 br=0",
                         bus.state, bus.stop, bus.ball_reset);
    end
  endtask

  task automatic test_time_bcd();
    int guard;
    do_reset();
    go_play();
    cyc(1, 0, 0, 0);
    checks++;
    if ({bus.min, bus.sec_tens, bus.sec_ones} !== 12'h259) begin
      errors++; $display("FAIL time_300 got %h want 259", {bus.min, bus.sec_tens, bus.sec_ones});
    end
    guard = 0;
    while (m_secs != 120 && guard < 200) begin cyc(1, 0, 0, 0); guard++; end
    checks++;
    if ({bus.min, bus.sec_tens, bus.sec_ones} !== 12'h200) begin
      errors++; $display("FAIL time_at_200 got %h want 200", {bus.min, bus.sec_tens, bus.sec_ones});
    end
    cyc(1, 0, 0, 0);
    checks++;
    if ({bus.min, bus.sec_tens, bus.sec_ones} !== 12'h159) begin
      errors++; $display("FAIL time_200 got %h want 159", {bus.min, bus.sec_tens, bus.sec_ones});
    end
    guard = 0;
    while (m_secs != 10 && guard < 200) begin cyc(1, 0, 0, 0); guard++; end
    cyc(1, 0, 0, 0);
    checks++;
    if ({bus.min, bus.sec_tens, bus.sec_ones} !== 12'h009 || bus.state !== 2'd1) begin
      errors++; $display("FAIL time_010 got %h want 009", {bus.min, bus.sec_tens, bus.sec_ones});
    end
  endtask

  task automatic test_double_miss();
    do_reset();
    go_play();
    cyc(0, 0, 0, 1);
    checks++;
    if (bus.score1 !== 3'd1 || bus.serve_dir !== 1'b1 || bus.state !== 2'd2) begin
      errors++; $display("FAIL miss2 got s1=%0d dir=%0d want s1=1 dir=1", bus.score1, bus.serve_dir);
    end
    serve_to_play();
    cyc(0, 0, 1, 1);
    checks++;
    if (bus.score2 !== 3'd1 || bus.score1 !== 3'd1 || bus.serve_dir !== 1'b0 ||
        bus.state !== 2'd2 || bus.ball_reset !== 1'b1) begin
      errors++; $display("FAIL double_miss got %h want %h", dut_vec(), exp_vec());
    end
    cyc(0, 0, 0, 0);
    checks++;
    if (bus.ball_reset !== 1'b0 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL double_miss_br got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_win();
    do_reset();
    go_play();
    for (int i = 0; i < 6; i++) begin cyc(0, 0, 0, 1); serve_to_play(); end
    checks++;
    if (bus.score1 !== 3'd6 || bus.state !== 2'd1) begin
      errors++; $display("FAIL win_pre got s1=%0d want 6", bus.score1);
    end
    cyc(0, 0, 0, 1);
    checks++;
    if (bus.score1 !== 3'd7 || bus.state !== 2'd3 || bus.winner !== 2'd1 || bus.ball_reset !== 1'b0) begin
      errors++; $display("FAIL win_over got %h want %h", dut_vec(), exp_vec());
    end
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 1); cyc(1, 0, 0, 0);
    checks++;
    if (bus.score1 !== 3'd7 || bus.score2 !== 3'd0 || bus.state !== 2'd3) begin
      errors++; $display("FAIL over_hold got %h want %h", dut_vec(), exp_vec());
    end
    cyc(0, 1, 0, 0);
    checks++;
    if (dut_vec() !== {2'd0, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 4'd3, 4'd0, 4'd0, 2'd0}) begin
      errors++; $display("FAIL over_to_idle got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_timeout();
    int guard;
    do_reset();
    go_play();
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 1, 0); serve_to_play();
      cyc(0, 0, 0, 1); serve_to_play();
    end
    guard = 0;
    while (m_secs != 1 && guard < 300) begin cyc(1, 0, 0, 0); guard++; end
    checks++;
    if ({bus.min, bus.sec_tens, bus.sec_ones} !== 12'h001 || bus.score1 !== 3'd2 || bus.score2 !== 3'd2) begin
      errors++; $display("FAIL timeout_pre got %h want %h", dut_vec(), exp_vec());
    end
    cyc(1, 0, 1, 0);
    checks++;
    if (bus.score2 !== 3'd3 || {bus.min, bus.sec_tens, bus.sec_ones} !== 12'h000 ||
        bus.state !== 2'd3 || bus.winner !== 2'd2 || bus.ball_reset !== 1'b0) begin
      errors++; $display("FAIL timeout got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_rst_mid_play();
    do_reset();
    go_play();
    cyc(0, 0, 1, 0);
    serve_to_play();
    cyc(1, 0, 0, 0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (bus.state !== 2'd0 || bus.stop !== 1'b1 || bus.score2 !== 3'd0 ||
        {bus.min, bus.sec_tens, bus.sec_ones} !== 12'h300) begin
      errors++; $display("FAIL rst_mid_play got %h want %h", dut_vec(), exp_vec());
    end
    @(negedge clk) rst = 1'b0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    checks++;
    if (dut_vec() !== exp_vec() || bus.ball_reset !== 1'b0) begin
      errors++; $display("FAIL rst_release got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_start_held();
    bus.start = 1'b1;
    rst = 1'b1;
    model_reset();
    #3 rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    checks++;
    if (bus.state !== 2'd0) begin
      errors++; $display("FAIL start_held got %0d want 0", bus.state);
    end
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    checks++;
    if (bus.state !== 2'd2 || bus.ball_reset !== 1'b1) begin
      errors++; $display("FAIL start_after_low got %0d want 2", bus.state);
    end
  endtask

  task automatic test_random();
    bit s;
    do_reset();
    s = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) s = ~s;
      if ($urandom_range(0, 699) == 0) begin
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== exp_vec()) begin
          errors++; $display("FAIL rand_rst got %h want %h", dut_vec(), exp_vec());
        end
        @(negedge clk) rst = 1'b0;
      end
      cyc($urandom_range(0, 2) == 0, s, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL rand_cycle_%0d got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start_serve_play();
    test_time_bcd();
    test_double_miss();
    test_win();
    test_timeout();
    test_rst_mid_play();
    test_start_held();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
